// File: rtl/batt_pkg.sv
// Shared types and constants for the battery gauge.
// BATT_FAST_CHARGE_EN selects a 250 ms charge step instead of 1 s.
package batt_pkg;

  typedef enum logic [1:0] {
    ST_DISCHARGE = 2'd0,
    ST_CHARGE    = 2'd1,
    ST_FULL      = 2'd2,
    ST_EMPTY     = 2'd3
  } batt_state_e;

  localparam logic [6:0] LEVEL_MAX  = 7'd99;
  localparam logic [6:0] LOW_THRESH = 7'd25;

  // Step periods are counted in quarter ticks (250 ms each).
  localparam logic [4:0] DRAIN_PERIOD_LOW  = 5'd16;
  localparam logic [4:0] DRAIN_PERIOD_MID  = 5'd8;
  localparam logic [4:0] DRAIN_PERIOD_HIGH = 5'd4;

`ifdef BATT_FAST_CHARGE_EN
  localparam logic [4:0] CHARGE_PERIOD = 5'd1;
`else
  localparam logic [4:0] CHARGE_PERIOD = 5'd4;
`endif

  // A period of zero means "no stepping": the accumulator holds.
  function automatic logic [4:0] drain_period(input logic [1:0] fan);
    case (fan)
      2'd1:    drain_period = DRAIN_PERIOD_LOW;
      2'd2:    drain_period = DRAIN_PERIOD_MID;
      2'd3:    drain_period = DRAIN_PERIOD_HIGH;
      default: drain_period = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/charger_debounce.sv
// Two-flop synchronizer plus debounce counter for the raw charger input.
module charger_debounce #(
  parameter int DEBOUNCE_CYC = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic clean_out
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic             sync1_q, sync2_q;
  logic             clean_q, clean_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: always_comb assigns every output a default first so no latch is inferred.
  always_comb begin
    clean_d = clean_q;
    cnt_d   = '0;
    if (sync2_q != clean_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
        clean_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      clean_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clean_out = clean_q;

endmodule

// File: rtl/battery_gauge.sv
// Battery level model: quarter-tick prescaler, step accumulator, state machine.
// Build option: BATT_FAST_CHARGE_EN (charge period taken from batt_pkg).
module battery_gauge
  import batt_pkg::*;
#(
  parameter int CLK_HZ       = 1000,
  parameter int INIT_LEVEL   = 99,
  parameter int DEBOUNCE_CYC = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       charger_in,
  input  logic [1:0] fan_state,
  output logic [7:0] battery,
  output logic       charging,
  output logic       full,
  output logic       low,
  output logic       empty
);

  localparam int QTR     = CLK_HZ / 4;
  localparam int PRESC_W = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [6:0] INIT_LVL = 7'(INIT_LEVEL);
  localparam batt_state_e INIT_STATE = (INIT_LEVEL == 99) ? ST_FULL :
                                       (INIT_LEVEL == 0)  ? ST_EMPTY : ST_DISCHARGE;

  logic               plugged;
  logic               qtick;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [4:0]         acc_q, acc_d;
  logic [4:0]         period;
  logic               step;
  batt_state_e        state_q, state_d;
  logic [6:0]         level_q, level_d;
  logic               charging_q, full_q, low_q, empty_q;

  charger_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_in    (charger_in),
    .clean_out (plugged)
  );

  assign qtick   = (presc_q == PRESC_W'(QTR - 1));
  assign presc_d = qtick ? '0 : presc_q + PRESC_W'(1);

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    acc_d   = acc_q;
    step    = 1'b0;

    case (state_q)
      ST_DISCHARGE: period = drain_period(fan_state);
      ST_CHARGE:    period = CHARGE_PERIOD;
      default:      period = 5'd0;
    endcase

    if (qtick && period != 5'd0) begin
      step  = (acc_q >= period - 5'd1);
      acc_d = step ? 5'd0 : acc_q + 5'd1;
    end

    // Plug/unplug is checked first so it overrides a coincident step.
    case (state_q)
      ST_DISCHARGE: begin
        if (plugged) begin
          state_d = (level_q == LEVEL_MAX) ? ST_FULL : ST_CHARGE;
        end else if (step && level_q != 7'd0) begin
          level_d = level_q - 7'd1;
          if (level_q == 7'd1) state_d = ST_EMPTY;
        end
      end
      ST_CHARGE: begin
        if (!plugged) begin
          state_d = ST_DISCHARGE;
        end else if (step && level_q < LEVEL_MAX) begin
          level_d = level_q + 7'd1;
          if (level_q == LEVEL_MAX - 7'd1) state_d = ST_FULL;
        end
      end
      ST_FULL:  if (!plugged) state_d = ST_DISCHARGE;
      ST_EMPTY: if (plugged)  state_d = ST_CHARGE;
      default:  state_d = ST_DISCHARGE;
    endcase

    if (state_d != state_q) acc_d = 5'd0;
  end

  // Flags are registered from the next-state values so they move with battery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      acc_q      <= 5'd0;
      state_q    <= INIT_STATE;
      level_q    <= INIT_LVL;
      charging_q <= 1'b0;
      full_q     <= (INIT_LVL == LEVEL_MAX);
      low_q      <= (INIT_LVL <= LOW_THRESH);
      empty_q    <= (INIT_LEVEL == 0);
    end else begin
      presc_q    <= presc_d;
      acc_q      <= acc_d;
      state_q    <= state_d;
      level_q    <= level_d;
      charging_q <= (state_d == ST_CHARGE);
      full_q     <= (level_d == LEVEL_MAX);
      low_q      <= (level_d <= LOW_THRESH);
      empty_q    <= (state_d == ST_EMPTY);
    end
  end

  assign battery  = {1'b0, level_q};
  assign charging = charging_q;
  assign full     = full_q;
  assign low      = low_q;
  assign empty    = empty_q;

endmodule

// File: tb/tb_battery_gauge.sv
// Directed bench for battery_gauge: four instances (CLK_HZ=8, DEBOUNCE_CYC=3)
// with different INIT_LEVEL values, each released from reset for its own scenario.
module tb_battery_gauge;

`ifdef BATT_FAST_CHARGE_EN
  localparam int CH_CYC = 2;
`else
  localparam int CH_CYC = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n    [4];
  logic       chg_in   [4];
  logic [1:0] fan      [4];
  logic [7:0] batt     [4];
  logic       charging [4];
  logic       full     [4];
  logic       low      [4];
  logic       empty    [4];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  battery_gauge #(.CLK_HZ(8), .INIT_LEVEL(99), .DEBOUNCE_CYC(3)) u_g0 (
    .clk(clk), .rst_n(rst_n[0]), .charger_in(chg_in[0]), .fan_state(fan[0]),
    .battery(batt[0]), .charging(charging[0]), .full(full[0]), .low(low[0]), .empty(empty[0]));
  battery_gauge #(.CLK_HZ(8), .INIT_LEVEL(1), .DEBOUNCE_CYC(3)) u_g1 (
    .clk(clk), .rst_n(rst_n[1]), .charger_in(chg_in[1]), .fan_state(fan[1]),
    .battery(batt[1]), .charging(charging[1]), .full(full[1]), .low(low[1]), .empty(empty[1]));
  battery_gauge #(.CLK_HZ(8), .INIT_LEVEL(97), .DEBOUNCE_CYC(3)) u_g2 (
    .clk(clk), .rst_n(rst_n[2]), .charger_in(chg_in[2]), .fan_state(fan[2]),
    .battery(batt[2]), .charging(charging[2]), .full(full[2]), .low(low[2]), .empty(empty[2]));
  battery_gauge #(.CLK_HZ(8), .INIT_LEVEL(26), .DEBOUNCE_CYC(3)) u_g3 (
    .clk(clk), .rst_n(rst_n[3]), .charger_in(chg_in[3]), .fan_state(fan[3]),
    .battery(batt[3]), .charging(charging[3]), .full(full[3]), .low(low[3]), .empty(empty[3]));

  typedef struct {
    logic [1:0] fan;
    int         cycles;
    int         batt;
    logic [3:0] flags;   // {charging, full, low, empty}
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_out(input string name, input int idx, input int exp_batt,
                           input logic [3:0] exp_flags);
    check({name, ".battery"}, int'(batt[idx]), exp_batt);
    check({name, ".flags"}, int'({charging[idx], full[idx], low[idx], empty[idx]}),
          int'(exp_flags));
  endtask

  initial begin
    // Instance 0 (INIT 99): qticks fall on every even edge after reset release.
    vecs[0]  = '{2'd3, 0,  99, 4'b0100};
    vecs[1]  = '{2'd3, 7,  99, 4'b0100};
    vecs[2]  = '{2'd3, 1,  98, 4'b0000};
    vecs[3]  = '{2'd3, 8,  97, 4'b0000};
    vecs[4]  = '{2'd0, 20, 97, 4'b0000};
    vecs[5]  = '{2'd2, 15, 97, 4'b0000};
    vecs[6]  = '{2'd2, 1,  96, 4'b0000};
    vecs[7]  = '{2'd1, 20, 96, 4'b0000};   // acc reaches 10, below 15
    vecs[8]  = '{2'd3, 1,  96, 4'b0000};
    vecs[9]  = '{2'd3, 1,  95, 4'b0000};   // acc 10 > 3 fires on next qtick
    vecs[10] = '{2'd3, 7,  95, 4'b0000};
    vecs[11] = '{2'd3, 1,  94, 4'b0000};

    for (int i = 0; i < 4; i++) begin
      rst_n[i]  = 1'b0;
      chg_in[i] = 1'b0;
    end
    fan[0] = 2'd3;
    fan[1] = 2'd1;
    fan[2] = 2'd0;
    fan[3] = 2'd3;

    @(negedge clk);
    check_out("rst1", 1, 1,  4'b0010);
    check_out("rst2", 2, 97, 4'b0000);
    check_out("rst3", 3, 26, 4'b0000);

    // Table-driven drain / period-switch sequence.
    @(negedge clk);
    rst_n[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      fan[0] = vecs[i].fan;
      repeat (vecs[i].cycles) @(negedge clk);
      check_out($sformatf("vec%0d", i), 0, vecs[i].batt, vecs[i].flags);
    end

    // Drain to empty, hold, then debounce.
    rst_n[1] = 1'b1;
    repeat (31) @(negedge clk);
    check_out("drain_pre", 1, 1, 4'b0010);
    @(negedge clk);
    check_out("drain_empty", 1, 0, 4'b0011);
    repeat (200) @(negedge clk);
    check_out("empty_hold", 1, 0, 4'b0011);
    chg_in[1] = 1'b1;
    repeat (2) @(negedge clk);
    chg_in[1] = 1'b0;
    repeat (10) @(negedge clk);
    check_out("bounce_reject", 1, 0, 4'b0011);
    chg_in[1] = 1'b1;
    repeat (5) @(negedge clk);
    check_out("plug_pre", 1, 0, 4'b0011);
    @(negedge clk);
    check_out("plug_charge", 1, 0, 4'b1010);

    // Charge to full.
    rst_n[2]  = 1'b1;
    chg_in[2] = 1'b1;
    repeat (5) @(negedge clk);
    check_out("chg_pre", 2, 97, 4'b0000);
    @(negedge clk);
    check_out("chg_rise", 2, 97, 4'b1000);
    repeat (CH_CYC - 1) @(negedge clk);
    check_out("chg_97", 2, 97, 4'b1000);
    @(negedge clk);
    check_out("chg_98", 2, 98, 4'b1000);
    repeat (CH_CYC - 1) @(negedge clk);
    check_out("chg_98b", 2, 98, 4'b1000);
    @(negedge clk);
    check_out("chg_full", 2, 99, 4'b0100);

    // Low threshold, then async reset in the middle of charging.
    rst_n[3] = 1'b1;
    repeat (7) @(negedge clk);
    check_out("thr_26", 3, 26, 4'b0000);
    @(negedge clk);
    check_out("thr_25", 3, 25, 4'b0010);
    chg_in[3] = 1'b1;
    repeat (6) @(negedge clk);
    check_out("thr_charge", 3, 25, 4'b1010);
    for (int k = 0; k < 400 && batt[3] != 8'd40; k++) @(negedge clk);
    check("reach_40", int'(batt[3] == 8'd40), 1);
    check_out("at_40", 3, 40, 4'b1000);
    #2 rst_n[3] = 1'b0;
    #1;
    check_out("async_rst", 3, 26, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
